game_timer_bcd: RTL and testbench

Parametrised BCD game timer for cartridge logic. It divides `sys_clk` down to a game tick and counts a configurable number of BCD digits up (elapsed time) or down (countdown) with run/pause control. It freezes on `game_won`/`game_over` and reports saturation or expiry. It feeds the HUD score/time digit renderer and the game-end logic.

---
 rtl/game_timer_bcd_pkg.sv | 19 +
 rtl/game_timer_bcd_bcd_digit.sv | 48 ++++
 rtl/game_timer_bcd.sv | 146 ++++++++++++++
 tb/tb_game_timer_bcd.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_bcd_pkg.sv
// rtl/game_timer_bcd_pkg.sv - FSM encoding and BCD constants shared by the game timer, HUD and game-end logic
package game_timer_bcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_FROZEN = 3'd3,
    ST_DONE   = 3'd4
  } timer_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Presets arrive from cartridge data; anything above 9 is treated as 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/game_timer_bcd_bcd_digit.sv
// rtl/game_timer_bcd_bcd_digit.sv - one BCD nibble with carry/borrow chaining
module bcd_digit
  import game_timer_bcd_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       term
);

  logic       at_term;
  logic [3:0] digit_next;

  assign at_term = dir ? (digit == 4'd0) : (digit == BCD_MAX);
  assign cout    = cin & at_term;

  always_comb begin
    digit_next = digit;
    if (cin) begin
      if (dir)
        digit_next = at_term ? BCD_MAX : digit - 4'd1;
      else
        digit_next = at_term ? 4'd0 : digit + 4'd1;
    end
  end

  // term looks ahead: the value this digit would hold after the pending step
  assign term = dir ? (digit_next == 4'd0) : (digit_next == BCD_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      digit <= 4'd0;
    else if (clr)
      digit <= 4'd0;
    else if (load)
      digit <= load_val;
    else if (en)
      digit <= digit_next;
  end

endmodule

// File: rtl/game_timer_bcd.sv
// rtl/game_timer_bcd.sv - prescaled BCD up/down game timer with run/pause/freeze control
module game_timer_bcd
  import game_timer_bcd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DIGITS      = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                time_clr,
  input  logic                start,
  input  logic                pause,
  input  logic                dir,
  input  logic                load_en,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                game_won,
  input  logic                game_over,
  output logic [4*DIGITS-1:0] time_bcd,
  output logic                tick_pulse,
  output logic                time_max_flag,
  output logic                time_zero_flag,
  output logic [2:0]          timer_state
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  timer_state_e  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          max_q, max_d;
  logic          zero_q, zero_d;
  logic          tick_q;
  logic          tick_now;
  logic          freeze;
  logic          dir_eff;
  logic          digit_load;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] digit_term;

  assign freeze     = game_won | game_over;
  // In IDLE the chain looks at the live dir so carry[DIGITS] flags a zero count before a down start.
  assign dir_eff    = (state_q == ST_IDLE) ? dir : dir_q;
  assign digit_load = load_en && (state_q == ST_IDLE) && !time_clr;
  assign carry[0]   = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] lv_clamped;
    assign lv_clamped = bcd_clamp(load_val[4*g +: 4]);

    bcd_digit u_digit (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr       (time_clr),
      .load      (digit_load),
      .load_val  (lv_clamped),
      .en        (tick_now),
      .dir       (dir_eff),
      .cin       (carry[g]),
      .digit     (time_bcd[4*g +: 4]),
      .cout      (carry[g+1]),
      .term      (digit_term[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    max_d    = max_q;
    zero_d   = zero_q;
    tick_now = 1'b0;
    if (time_clr) begin
      state_d = ST_IDLE;
      presc_d = '0;
      max_d   = 1'b0;
      zero_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !pause) begin
            dir_d   = dir;
            presc_d = '0;
            if (dir && carry[DIGITS]) begin
              state_d = ST_DONE;
              zero_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Freeze and pause outrank a tick due this cycle; that tick is dropped.
          if (freeze) begin
            state_d = ST_FROZEN;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            tick_now = 1'b1;
            presc_d  = '0;
            if (&digit_term) begin
              state_d = ST_DONE;
              if (dir_q) zero_d = 1'b1;
              else       max_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (freeze)
            state_d = ST_FROZEN;
          else if (!pause && start)
            state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      dir_q   <= 1'b0;
      max_q   <= 1'b0;
      zero_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      max_q   <= max_d;
      zero_q  <= zero_d;
      tick_q  <= tick_now;
    end
  end

  assign tick_pulse     = tick_q;
  assign time_max_flag  = max_q;
  assign time_zero_flag = zero_q;
  assign timer_state    = state_q;

endmodule

// File: tb/tb_game_timer_bcd.sv
// tb/tb_game_timer_bcd.sv - directed table-driven bench for game_timer_bcd (DIV=10, DIGITS=3)
module tb_game_timer_bcd;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        time_clr;
  logic        start;
  logic        pause;
  logic        dir;
  logic        load_en;
  logic [11:0] load_val;
  logic        game_won;
  logic        game_over;
  logic [11:0] time_bcd;
  logic        tick_pulse;
  logic        time_max_flag;
  logic        time_zero_flag;
  logic [2:0]  timer_state;

  int checks = 0;
  int errors = 0;

  game_timer_bcd #(
    .CLK_FREQ_HZ (10),
    .TICK_HZ     (1),
    .DIGITS      (3)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .time_clr       (time_clr),
    .start          (start),
    .pause          (pause),
    .dir            (dir),
    .load_en        (load_en),
    .load_val       (load_val),
    .game_won       (game_won),
    .game_over      (game_over),
    .time_bcd       (time_bcd),
    .tick_pulse     (tick_pulse),
    .time_max_flag  (time_max_flag),
    .time_zero_flag (time_zero_flag),
    .timer_state    (timer_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        clr;
    logic        ld;
    logic [11:0] lv;
    logic        st;
    logic        dr;
    int          n;
    logic [11:0] e_bcd;
    logic [2:0]  e_st;
    logic        e_max;
    logic        e_zero;
    int          e_ticks;
  } vec_t;

  vec_t vecs[16];
  int   ticks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (tick_pulse) ticks++;
  endtask

  function automatic vec_t mk(input logic clr, input logic ld, input logic [11:0] lv,
                              input logic st, input logic dr, input int n,
                              input logic [11:0] e_bcd, input logic [2:0] e_st,
                              input logic e_max, input logic e_zero, input int e_ticks);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.st = st; v.dr = dr; v.n = n;
    v.e_bcd = e_bcd; v.e_st = e_st; v.e_max = e_max; v.e_zero = e_zero; v.e_ticks = e_ticks;
    return v;
  endfunction

  initial begin
    //               clr ld  lv      st  dr  n    bcd     st    max zero ticks
    vecs[0]  = mk(1, 0, 12'h000, 0, 0, 1,   12'h000, 3'd0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 12'h000, 1, 0, 101, 12'h010, 3'd1, 0, 0, 10);
    vecs[2]  = mk(1, 0, 12'h000, 0, 0, 1,   12'h000, 3'd0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 12'h998, 0, 0, 1,   12'h998, 3'd0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 12'h000, 1, 0, 11,  12'h999, 3'd4, 1, 0, 1);
    vecs[5]  = mk(0, 0, 12'h000, 1, 0, 50,  12'h999, 3'd4, 1, 0, 0);
    vecs[6]  = mk(1, 0, 12'h000, 0, 0, 1,   12'h000, 3'd0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 12'h010, 0, 1, 1,   12'h010, 3'd0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 12'h000, 1, 1, 11,  12'h009, 3'd1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 12'h000, 1, 1, 90,  12'h000, 3'd4, 0, 1, 9);
    vecs[10] = mk(1, 0, 12'h000, 0, 0, 1,   12'h000, 3'd0, 0, 0, 0);
    vecs[11] = mk(0, 1, 12'h000, 0, 1, 1,   12'h000, 3'd0, 0, 0, 0);
    vecs[12] = mk(0, 0, 12'h000, 1, 1, 6,   12'h000, 3'd4, 0, 1, 0);
    vecs[13] = mk(1, 0, 12'h000, 0, 0, 1,   12'h000, 3'd0, 0, 0, 0);
    vecs[14] = mk(0, 1, 12'h0A5, 0, 0, 1,   12'h095, 3'd0, 0, 0, 0);
    vecs[15] = mk(1, 0, 12'h000, 0, 0, 1,   12'h000, 3'd0, 0, 0, 0);

    sys_rst_n = 1'b0;
    time_clr = 0; start = 0; pause = 0; dir = 0; load_en = 0; load_val = '0;
    game_won = 0; game_over = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_bcd",   32'(time_bcd), 32'h000);
    chk("reset_state", 32'(timer_state), 32'd0);
    chk("reset_tick",  32'(tick_pulse), 32'd0);
    chk("reset_max",   32'(time_max_flag), 32'd0);
    chk("reset_zero",  32'(time_zero_flag), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      time_clr = vecs[i].clr;
      load_en  = vecs[i].ld;
      load_val = vecs[i].lv;
      start    = vecs[i].st;
      dir      = vecs[i].dr;
      ticks    = 0;
      for (int c = 0; c < vecs[i].n; c++) step();
      chk($sformatf("vec%0d_bcd", i),   32'(time_bcd), 32'(vecs[i].e_bcd));
      chk($sformatf("vec%0d_state", i), 32'(timer_state), 32'(vecs[i].e_st));
      chk($sformatf("vec%0d_max", i),   32'(time_max_flag), 32'(vecs[i].e_max));
      chk($sformatf("vec%0d_zero", i),  32'(time_zero_flag), 32'(vecs[i].e_zero));
      chk($sformatf("vec%0d_ticks", i), 32'(ticks), 32'(vecs[i].e_ticks));
    end
    time_clr = 0; load_en = 0; start = 0; dir = 0;

    // Pause at prescaler 6 for 37 cycles; the tick must land 4 RUN cycles after resume.
    begin
      int n;
      ticks = 0;
      start = 1;
      repeat (7) step();
      chk("pause_pre_ticks", 32'(ticks), 32'd0);
      pause = 1;
      repeat (37) step();
      chk("pause_state", 32'(timer_state), 32'd2);
      chk("pause_ticks", 32'(ticks), 32'd0);
      pause = 0;
      step();
      chk("resume_state", 32'(timer_state), 32'd1);
      chk("resume_edge_tick", 32'(tick_pulse), 32'd0);
      n = 0;
      do begin
        step();
        n++;
      end while (!tick_pulse && n < 20);
      chk("resume_tick_delay", 32'(n), 32'd4);
      chk("resume_bcd", 32'(time_bcd), 32'h001);
      step();
      chk("tick_one_cycle", 32'(tick_pulse), 32'd0);
    end

    // game_over on the tick cycle drops the tick and freezes the preset value.
    start = 0; time_clr = 1; step(); time_clr = 0;
    load_en = 1; load_val = 12'h123; step(); load_en = 0;
    start = 1; ticks = 0;
    repeat (10) step();
    chk("frz_pre_ticks", 32'(ticks), 32'd0);
    game_over = 1;
    step();
    game_over = 0;
    chk("frz_state", 32'(timer_state), 32'd3);
    chk("frz_tick", 32'(tick_pulse), 32'd0);
    chk("frz_bcd", 32'(time_bcd), 32'h123);
    ticks = 0;
    repeat (20) step();
    chk("frz_hold_bcd", 32'(time_bcd), 32'h123);
    chk("frz_hold_ticks", 32'(ticks), 32'd0);
    chk("frz_hold_state", 32'(timer_state), 32'd3);
    start = 0; time_clr = 1; step(); time_clr = 0;
    chk("frz_clr_bcd", 32'(time_bcd), 32'h000);
    chk("frz_clr_state", 32'(timer_state), 32'd0);

    // game_won while paused also freezes.
    start = 1; repeat (3) step();
    pause = 1; step();
    game_won = 1; step(); game_won = 0; pause = 0;
    chk("won_pause_state", 32'(timer_state), 32'd3);
    start = 0; time_clr = 1; step(); time_clr = 0;

    // Asynchronous reset between edges mid-count.
    start = 1; ticks = 0;
    repeat (25) step();
    chk("arst_pre_bcd", 32'(time_bcd), 32'h002);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_bcd",   32'(time_bcd), 32'h000);
    chk("arst_state", 32'(timer_state), 32'd0);
    chk("arst_tick",  32'(tick_pulse), 32'd0);
    chk("arst_flags", 32'({time_max_flag, time_zero_flag}), 32'd0);
    start = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step();
    chk("arst_after_state", 32'(timer_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
